// File: rtl/arb_out_buffer_if.sv
// rtl/arb_out_buffer_if.sv - arbiter/data-FIFO side signal bundle of the output buffer
interface arb_out_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  ARB_WRITE;
  logic [31:0]           ARB_DATA;
  logic                  ARB_READY;
  logic                  FIFO_WRITE;
  logic [31:0]           FIFO_DATA;
  logic                  FIFO_FULL;
  logic                  FIFO_NEAR_FULL;
  logic [DEPTH_LOG2:0]   FILL;
  logic [15:0]           LOST_CNT;
  logic [31:0]           WORD_CNT;

  // Drives the arbiter and data-FIFO status side, observes the buffer.
  modport master (
    output ARB_WRITE, ARB_DATA, FIFO_FULL, FIFO_NEAR_FULL,
    input  ARB_READY, FIFO_WRITE, FIFO_DATA, FILL, LOST_CNT, WORD_CNT
  );

  // The buffer itself.
  modport slave (
    input  ARB_WRITE, ARB_DATA, FIFO_FULL, FIFO_NEAR_FULL,
    output ARB_READY, FIFO_WRITE, FIFO_DATA, FILL, LOST_CNT, WORD_CNT
  );
endinterface

// File: rtl/arb_out_buffer.sv
// rtl/arb_out_buffer.sv - elastic buffer between readout arbiter and external data FIFO
module arb_out_buffer #(
  parameter int DEPTH_LOG2   = 4,
  parameter int READY_MARGIN = 2
) (
  input  logic               BUS_CLK,
  input  logic               BUS_RST,
  arb_out_buffer_if.slave    bus
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int FW    = DEPTH_LOG2 + 1;

  localparam logic [FW-1:0] FILL_MAX    = FW'(DEPTH);
  localparam logic [FW-1:0] READY_LIMIT = FW'(DEPTH - READY_MARGIN);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [FW-1:0]         fill;
  logic [FW-1:0]         fill_next;

  logic                  push;
  logic                  drop;
  logic                  pop;

  logic                  fifo_write_q;
  logic [31:0]           fifo_data_q;
  logic                  arb_ready_q;
  logic [15:0]           lost_cnt_q;
  logic [31:0]           word_cnt_q;

  // Decide push/drop/pop from pre-edge occupancy; a word pushed now cannot pop now.
  always_comb begin
    push      = bus.ARB_WRITE && (fill != FILL_MAX);
    drop      = bus.ARB_WRITE && (fill == FILL_MAX);
    pop       = (fill != '0) && !bus.FIFO_FULL;
    fill_next = fill;
    case ({push, pop})
      2'b10:   fill_next = fill + FW'(1);
      2'b01:   fill_next = fill - FW'(1);
      default: fill_next = fill;
    endcase
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge BUS_CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.ARB_DATA;
    end
  end

  // Pointers and occupancy; reset discards everything buffered.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fill <= fill_next;
    end
  end

  // Registered write strobe and data towards the data FIFO; data holds when idle.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
    end else if (pop) begin
      fifo_write_q <= 1'b1;
      fifo_data_q  <= mem[rd_ptr];
    end else begin
      fifo_write_q <= 1'b0;
    end
  end

  // Saturating drop counter and wrapping delivered-word counter.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      lost_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      if (drop && (lost_cnt_q != 16'hFFFF)) begin
        lost_cnt_q <= lost_cnt_q + 16'd1;
      end
      if (pop) begin
        word_cnt_q <= word_cnt_q + 32'd1;
      end
    end
  end

  // Advisory ready: leaves READY_MARGIN slots for words already in flight.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      arb_ready_q <= 1'b0;
    end else begin
      arb_ready_q <= (fill_next <= READY_LIMIT) && !bus.FIFO_NEAR_FULL;
    end
  end

  assign bus.ARB_READY  = arb_ready_q;
  assign bus.FIFO_WRITE = fifo_write_q;
  assign bus.FIFO_DATA  = fifo_data_q;
  assign bus.FILL       = fill;
  assign bus.LOST_CNT   = lost_cnt_q;
  assign bus.WORD_CNT   = word_cnt_q;
endmodule

// File: tb/tb_arb_out_buffer.sv
// tb/tb_arb_out_buffer.sv - directed vectors and corner sequences for arb_out_buffer
module tb_arb_out_buffer;
  logic BUS_CLK = 1'b0;
  logic BUS_RST = 1'b1;

  arb_out_buffer_if #(.DEPTH_LOG2(4)) bus ();

  arb_out_buffer #(.DEPTH_LOG2(4), .READY_MARGIN(2)) dut (
    .BUS_CLK (BUS_CLK),
    .BUS_RST (BUS_RST),
    .bus     (bus)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct {
    logic        wr;
    logic [31:0] din;
    logic        full;
    logic        nfull;
    logic        e_fw;
    logic [31:0] e_data;
    logic [4:0]  e_fill;
    logic        e_ready;
    logic [15:0] e_lost;
    logic [31:0] e_wc;
  } vec_t;

  vec_t tbl [11];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] din, input logic full, input logic nfull);
    bus.ARB_WRITE      = wr;
    bus.ARB_DATA       = din;
    bus.FIFO_FULL      = full;
    bus.FIFO_NEAR_FULL = nfull;
  endtask

  initial begin
    int exp_fill;
    drive(1'b0, 32'h0, 1'b0, 1'b0);

    // rows: wr din full nfull | fw data fill ready lost wc
    tbl[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        5'd0, 1'b1, 16'd0, 32'd0};
    tbl[1]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        5'd1, 1'b1, 16'd0, 32'd0};
    tbl[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 5'd0, 1'b1, 16'd0, 32'd1};
    tbl[3]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 5'd0, 1'b1, 16'd0, 32'd1};
    tbl[4]  = '{1'b1, 32'hA1,       1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 5'd1, 1'b1, 16'd0, 32'd1};
    tbl[5]  = '{1'b1, 32'hA2,       1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 5'd2, 1'b1, 16'd0, 32'd1};
    tbl[6]  = '{1'b1, 32'hA3,       1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 5'd3, 1'b1, 16'd0, 32'd1};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA1,       5'd2, 1'b0, 16'd0, 32'd2};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hA2,       5'd1, 1'b0, 16'd0, 32'd3};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA3,       5'd0, 1'b1, 16'd0, 32'd4};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hA3,       5'd0, 1'b1, 16'd0, 32'd4};

    // Reset state
    step();
    step();
    chk("rst_fifo_write", 32'(bus.FIFO_WRITE), 32'd0);
    chk("rst_fifo_data",  bus.FIFO_DATA,       32'd0);
    chk("rst_arb_ready",  32'(bus.ARB_READY),  32'd0);
    chk("rst_fill",       32'(bus.FILL),       32'd0);
    chk("rst_lost",       32'(bus.LOST_CNT),   32'd0);
    chk("rst_word_cnt",   bus.WORD_CNT,        32'd0);
    BUS_RST = 1'b0;

    // Single word, then near-full throttling while draining
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].wr, tbl[i].din, tbl[i].full, tbl[i].nfull);
      step();
      chk($sformatf("v%0d_fifo_write", i), 32'(bus.FIFO_WRITE), 32'(tbl[i].e_fw));
      chk($sformatf("v%0d_fifo_data", i),  bus.FIFO_DATA,       tbl[i].e_data);
      chk($sformatf("v%0d_fill", i),       32'(bus.FILL),       32'(tbl[i].e_fill));
      chk($sformatf("v%0d_arb_ready", i),  32'(bus.ARB_READY),  32'(tbl[i].e_ready));
      chk($sformatf("v%0d_lost", i),       32'(bus.LOST_CNT),   32'(tbl[i].e_lost));
      chk($sformatf("v%0d_word_cnt", i),   bus.WORD_CNT,        tbl[i].e_wc);
    end

    // Backpressure: 20 writes into a blocked FIFO, 16 kept, 4 dropped
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'(i), 1'b1, 1'b0);
      step();
      exp_fill = (i + 1 > 16) ? 16 : i + 1;
      chk($sformatf("bp%0d_fill", i),      32'(bus.FILL),      32'(exp_fill));
      chk($sformatf("bp%0d_arb_ready", i), 32'(bus.ARB_READY), (exp_fill <= 14) ? 32'd1 : 32'd0);
      chk($sformatf("bp%0d_lost", i),      32'(bus.LOST_CNT),  (i >= 16) ? 32'(i - 15) : 32'd0);
      chk($sformatf("bp%0d_fifo_write", i), 32'(bus.FIFO_WRITE), 32'd0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("bp_hold_fill", 32'(bus.FILL), 32'd16);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("bpd%0d_fifo_write", k), 32'(bus.FIFO_WRITE), 32'd1);
      chk($sformatf("bpd%0d_fifo_data", k),  bus.FIFO_DATA,       32'(k));
      chk($sformatf("bpd%0d_fill", k),       32'(bus.FILL),       32'(15 - k));
      chk($sformatf("bpd%0d_arb_ready", k),  32'(bus.ARB_READY),  (k == 0) ? 32'd0 : 32'd1);
    end
    chk("bp_word_cnt", bus.WORD_CNT, 32'd20);
    step();
    chk("bp_idle_fifo_write", 32'(bus.FIFO_WRITE), 32'd0);

    // Full buffer: a write in the same cycle as the first pop is still dropped
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'(200 + i), 1'b1, 1'b0);
      step();
    end
    chk("fp_fill_full", 32'(bus.FILL), 32'd16);
    drive(1'b1, 32'hBAD, 1'b0, 1'b0);
    step();
    chk("fp_fill", 32'(bus.FILL), 32'd15);
    chk("fp_lost", 32'(bus.LOST_CNT), 32'd5);
    chk("fp_fifo_write", 32'(bus.FIFO_WRITE), 32'd1);
    chk("fp_fifo_data", bus.FIFO_DATA, 32'd200);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("fpd%0d_fifo_data", k), bus.FIFO_DATA, 32'(201 + k));
      chk($sformatf("fpd%0d_fifo_write", k), 32'(bus.FIFO_WRITE), 32'd1);
    end
    step();
    chk("fp_idle_fifo_write", 32'(bus.FIFO_WRITE), 32'd0);
    chk("fp_word_cnt", bus.WORD_CNT, 32'd36);
    chk("fp_idle_fill", 32'(bus.FILL), 32'd0);

    // Streaming: 1000 back-to-back words at one per cycle
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 32'(i), 1'b0, 1'b0);
      step();
      chk($sformatf("st%0d_fill", i), 32'(bus.FILL), 32'd1);
      chk($sformatf("st%0d_arb_ready", i), 32'(bus.ARB_READY), 32'd1);
      chk($sformatf("st%0d_fifo_write", i), 32'(bus.FIFO_WRITE), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk($sformatf("st%0d_fifo_data", i), bus.FIFO_DATA, 32'(i - 1));
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("st_last_fifo_write", 32'(bus.FIFO_WRITE), 32'd1);
    chk("st_last_fifo_data", bus.FIFO_DATA, 32'd999);
    chk("st_fill", 32'(bus.FILL), 32'd0);
    chk("st_word_cnt", bus.WORD_CNT, 32'd1036);
    chk("st_lost", 32'(bus.LOST_CNT), 32'd5);

    // Reset mid-burst with FILL=9 and a pop in progress
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(300 + i), 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("mr_pre_fill", 32'(bus.FILL), 32'd9);
    chk("mr_pre_fifo_write", 32'(bus.FIFO_WRITE), 32'd1);
    chk("mr_pre_fifo_data", bus.FIFO_DATA, 32'd300);
    BUS_RST = 1'b1;
    step();
    chk("mr_fifo_write", 32'(bus.FIFO_WRITE), 32'd0);
    chk("mr_fill", 32'(bus.FILL), 32'd0);
    chk("mr_lost", 32'(bus.LOST_CNT), 32'd0);
    chk("mr_word_cnt", bus.WORD_CNT, 32'd0);
    chk("mr_fifo_data", bus.FIFO_DATA, 32'd0);
    chk("mr_arb_ready", 32'(bus.ARB_READY), 32'd0);
    BUS_RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("mra%0d_fifo_write", k), 32'(bus.FIFO_WRITE), 32'd0);
      chk($sformatf("mra%0d_fill", k), 32'(bus.FILL), 32'd0);
    end
    chk("mra_arb_ready", 32'(bus.ARB_READY), 32'd1);
    chk("mra_word_cnt", bus.WORD_CNT, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/arb_out_buffer.md
# arb_out_buffer

Elastic output stage between the readout round-robin arbiter and the external data FIFO. It accepts 32-bit words from the arbiter's write strobe and buffers them in a small first-in first-out memory. It drains them to the data FIFO at up to one word per clock while honouring FIFO_FULL, and throttles the arbiter through ARB_READY. Words offered while the buffer is full are dropped and counted, so data loss is visible to software.

## Interface
Parameters:
- DEPTH_LOG2, 4: buffer depth is 2^DEPTH_LOG2 words (16 by default).
- READY_MARGIN, 2: ARB_READY deasserts when fill > 2^DEPTH_LOG2 − READY_MARGIN.

Ports:
- BUS_CLK  in  1  the single clock; all logic is clocked on its rising edge.
- BUS_RST  in  1  reset, synchronous and active-high.
- ARB_WRITE  in  1  arbiter write strobe; one word per cycle while high.
- ARB_DATA  in  32  arbiter data word, valid with ARB_WRITE.
- ARB_READY  out  1  registered; buffer can take more words.
- FIFO_WRITE  out  1  registered; one-cycle write strobe to the data FIFO.
- FIFO_DATA  out  32  registered; word to the data FIFO, valid with FIFO_WRITE.
- FIFO_FULL  in  1  data FIFO cannot accept; inhibits draining.
- FIFO_NEAR_FULL  in  1  data FIFO nearly full; forces ARB_READY low.
- FILL  out  DEPTH_LOG2+1  current buffer occupancy, 0..2^DEPTH_LOG2.
- LOST_CNT  out  16  count of dropped words, saturating.
- WORD_CNT  out  32  count of words delivered to the data FIFO, wrapping.

## Operation
- Storage is a circular buffer with write pointer, read pointer and an occupancy counter FILL. The pointers are DEPTH_LOG2 bits wide and wrap modulo the depth.
- Push: at an edge with ARB_WRITE=1 and FILL < 2^DEPTH_LOG2 (pre-edge value), ARB_DATA is written at the write pointer and the write pointer increments.
- Drop: at an edge with ARB_WRITE=1 and FILL = 2^DEPTH_LOG2, the word is discarded and LOST_CNT increments, saturating at 0xFFFF. A pop in the same cycle does not rescue the word.
- Pop: at an edge with FILL > 0 (pre-edge) and FIFO_FULL=0:
  - FIFO_DATA loads the word at the read pointer.
  - FIFO_WRITE is set to 1.
  - The read pointer increments.
  - WORD_CNT increments, wrapping from 0xFFFFFFFF to 0.
- Otherwise FIFO_WRITE is set to 0 and FIFO_DATA holds its value.
- A word pushed at an edge is not popped at that same edge. An empty buffer never bypasses.
- Simultaneous push and pop leaves FILL unchanged. Push only adds 1 to FILL; pop only subtracts 1.
- ARB_READY is registered. It is set to 1 iff, after the edge update, FILL_next ≤ 2^DEPTH_LOG2 − READY_MARGIN and FIFO_NEAR_FULL=0.
- ARB_READY is advisory. The arbiter may still issue up to READY_MARGIN words in flight; these are accepted while space remains.
- Word order is preserved exactly. Nothing is generated, modified or duplicated.

## Timing
- Reset values:
  - FIFO_WRITE=0, FIFO_DATA=0, ARB_READY=0.
  - FILL=0, LOST_CNT=0, WORD_CNT=0.
  - Pointers are 0.
- ARB_READY rises on the first edge after BUS_RST is released.
- Reset mid-operation: all buffered words are discarded and all counters clear at the reset edge. FIFO_WRITE is 0 in the following cycle, even if a pop was pending.
- Latency: a word accepted at edge e0 into an empty buffer is presented with FIFO_WRITE=1 in the cycle after edge e1 (2 edges).
- Throughput: 1 word per cycle sustained when FIFO_FULL=0.
- FIFO_FULL is sampled at the edge. At most one word is already in flight on FIFO_WRITE when FIFO_FULL rises, so the data FIFO must assert FIFO_FULL with at least one word of headroom.
- FIFO_FULL falling: draining resumes with FIFO_WRITE=1 in the cycle after the first edge at which FIFO_FULL=0 is sampled.
- FILL, LOST_CNT and WORD_CNT are registered and update at the same edge as the corresponding push, drop or pop.

## Test plan
- Single word: after reset, ARB_WRITE=1 with 0xDEADBEEF for 1 cycle, FIFO_FULL=0 -> FIFO_WRITE high for exactly 1 cycle, 2 edges later, with FIFO_DATA=0xDEADBEEF; WORD_CNT=1; FILL returns to 0.
- Streaming: 1000 consecutive words 0..999 with FIFO_FULL=0 -> 1000 FIFO_WRITE pulses in order; FILL never exceeds 1; ARB_READY stays 1; LOST_CNT=0.
- Backpressure: hold FIFO_FULL=1 and write 20 words while ignoring ARB_READY:
  - ARB_READY falls once FILL reaches 15.
  - FILL saturates at 16, with words 0..15 stored.
  - Words 16..19 are dropped and LOST_CNT=4.
  - After FIFO_FULL is released, words 0..15 emerge in order and WORD_CNT=16.
- Full with simultaneous pop: FILL=16, FIFO_FULL falls in the same cycle as ARB_WRITE -> the word is dropped (LOST_CNT+1) and FILL=15 after the edge.
- FIFO_NEAR_FULL=1 with FILL=3 -> ARB_READY=0 at the next edge; draining continues; ARB_READY returns to 1 one edge after FIFO_NEAR_FULL falls.
- Reset mid-burst with FILL=9 and FIFO_WRITE active -> the next cycle shows FIFO_WRITE=0, FILL=0, LOST_CNT=0 and WORD_CNT=0; none of the pre-reset words emerge afterwards.
